// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: DATA_W payload, valid/ready handshake, 2-entry skid buffer.
// Latency: one cycle from acceptance to out_valid; one payload per cycle sustained.
// Backpressure: in_ready is registered (!skid_v), so at most one payload lands in skid after out_ready drops.
module pipe_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter int                STALL_W   = 6,
  parameter int                STAGE_IDX = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [STALL_W-1:0] flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Occupancy: EMPTY (main invalid), ONE (main only), FULL (main + skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic stall_b;
  logic flush_b;
  logic main_v;
  logic in_fire;
  logic out_fire;
  logic unused_ctrl;

  // Only this stage's bit of the shared control vectors matters; the rest are
  // folded into a sink so the full vectors can be wired straight through.
  assign stall_b     = stall[STAGE_IDX];
  assign flush_b     = flush[STAGE_IDX];
  assign unused_ctrl = ^{stall, flush};

  assign main_v   = (occ_q != EMPTY);
  // in_ready_q always mirrors !skid_v, so it doubles as the skid-free flag.
  assign in_fire  = in_valid & in_ready_q & ~stall_b & ~flush_b;
  assign out_fire = main_v & out_ready & ~stall_b & ~flush_b;

  // Next occupancy and data: flush beats stall, stall beats the handshake.
  always_comb begin
    occ_d      = occ_q;
    main_dat_d = main_dat_q;
    skid_dat_d = skid_dat_q;
    if (flush_b) begin
      occ_d      = EMPTY;
      main_dat_d = NOP_VALUE;
      skid_dat_d = NOP_VALUE;
    end else if (!stall_b) begin
      case (occ_q)
        EMPTY: begin
          if (in_fire) begin
            occ_d      = ONE;
            main_dat_d = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_dat_d = in_data;
          end else if (in_fire) begin
            occ_d      = FULL;
            skid_dat_d = in_data;
          end else if (out_fire) begin
            occ_d      = EMPTY;
            main_dat_d = NOP_VALUE;
          end
        end
        FULL: begin
          // Skid drains to main before anything newer; in_ready is low here.
          if (out_fire) begin
            occ_d      = ONE;
            main_dat_d = skid_dat_q;
          end
        end
        default: begin
          occ_d      = EMPTY;
          main_dat_d = NOP_VALUE;
          skid_dat_d = NOP_VALUE;
        end
      endcase
    end
  end

  // Registered ready and saturating performance counters (untouched by flush).
  always_comb begin
    in_ready_d   = (occ_d != FULL);
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (!main_v && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (stall_b && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards both entries without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q        <= EMPTY;
      main_dat_q   <= NOP_VALUE;
      skid_dat_q   <= NOP_VALUE;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      occ_q        <= occ_d;
      main_dat_q   <= main_dat_d;
      skid_dat_q   <= skid_dat_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_v;
  assign out_data   = main_v ? main_dat_q : NOP_VALUE;
  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed traffic, skid, stall, flush,
// async reset and counter saturation, with a per-cycle occupancy model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam int          SW  = 6;
  localparam int          IDX = 2;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall;
  logic [SW-1:0] flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] stall_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          bub_m = 0;
  int          stl_m = 0;
  logic [31:0] q[$];
  logic [31:0] exp_dat;
  bit          acc_in;

  pipe_stage_reg #(
    .DATA_W(DW), .STALL_W(SW), .STAGE_IDX(IDX), .NOP_VALUE(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = '0; flush = '0; in_valid = 1'b0; out_ready = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  // Model: queue of payloads held by the stage plus saturating counters.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      bub_m = 0;
      stl_m = 0;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    chk("out_data", out_data, (q.size() != 0) ? q[0] : NOP);
    chk("bubble_cnt", {28'b0, bubble_cnt}, bub_m);
    chk("stall_cnt", {28'b0, stall_cnt}, stl_m);
    if (rst) begin
      if (q.size() == 0 && bub_m < 15) bub_m++;
      if (stall[IDX] && stl_m < 15) stl_m++;
      if (flush[IDX]) begin
        q.delete();
      end else if (!stall[IDX]) begin
        acc_in = in_valid && (q.size() < 2);
        if (q.size() != 0 && out_ready) begin
          exp_dat = q.pop_front();
          chk("sb_data", out_data, exp_dat);
          n_out++;
        end
        if (acc_in) q.push_back(in_data);
      end
    end
  end

  initial begin
    rst = 1'b0; stall = '0; flush = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc(2);

    // Streaming at full rate
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1; cyc;
    in_data = 32'h22; cyc;
    in_data = 32'h33; cyc;
    in_valid = 1'b0;
    chk("stream_last", out_data, 32'h33);
    chk("stream_bub", {28'b0, bubble_cnt}, 32'd1);
    chk("stream_rdy", {31'b0, in_ready}, 32'd1);
    cyc(2);

    // Skid capture under backpressure; other stages' control bits toggled
    n_out = 0;
    stall = 6'b000011; flush = 6'b110000;
    in_valid = 1'b1; in_data = 32'hA0; out_ready = 1'b0; cyc;
    in_data = 32'hA1; cyc;
    chk("skid_rdy_low", {31'b0, in_ready}, 32'd0);
    in_data = 32'hA2; cyc(2);
    out_ready = 1'b1; cyc;
    chk("skid_mid", out_data, 32'hA1);
    cyc;
    in_valid = 1'b0;
    chk("skid_last", out_data, 32'hA2);
    cyc(2);
    chk("skid_count", n_out, 32'd3);
    stall = '0; flush = '0;

    // Stall with FULL occupancy
    do_reset();
    in_valid = 1'b1; in_data = 32'hB0; cyc;
    in_data = 32'hB1; cyc;
    in_data = 32'hB2; out_ready = 1'b1; stall = 6'b000100; cyc(4);
    chk("stall_cnt4", {28'b0, stall_cnt}, 32'd4);
    chk("stall_frozen", out_data, 32'hB0);
    chk("stall_rdy", {31'b0, in_ready}, 32'd0);
    stall = '0; in_valid = 1'b0; cyc(4);

    // Flush beats stall and drops the offered payload
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC0; cyc;
    in_data = 32'hC1; cyc;
    in_data = 32'hC2; out_ready = 1'b1; stall = 6'b000100; flush = 6'b000100; cyc;
    stall = '0; flush = '0; in_valid = 1'b0;
    chk("flush_v", {31'b0, out_valid}, 32'd0);
    chk("flush_d", out_data, NOP);
    chk("flush_rdy", {31'b0, in_ready}, 32'd1);
    cyc(3);

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD0; cyc;
    in_data = 32'hD1; cyc;
    #2 rst = 1'b0;
    #1;
    chk("ar_v", {31'b0, out_valid}, 32'd0);
    chk("ar_rdy", {31'b0, in_ready}, 32'd1);
    chk("ar_d", out_data, NOP);
    chk("ar_bub", {28'b0, bubble_cnt}, 32'd0);
    chk("ar_stl", {28'b0, stall_cnt}, 32'd0);
    in_valid = 1'b0; cyc;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1; cyc;
    in_valid = 1'b0;
    chk("ar_5a_v", {31'b0, out_valid}, 32'd1);
    chk("ar_5a_d", out_data, 32'h5A);
    cyc(2);

    // Bubble counter saturation
    do_reset();
    cyc(20);
    chk("bub_sat", {28'b0, bubble_cnt}, 32'hF);
    cyc(2);
    chk("bub_nowrap", {28'b0, bubble_cnt}, 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the in-order core, the generalised successor to the fixed-field inter-stage registers. Carries an opaque DATA_W-bit payload between two stages with a valid/ready handshake and a 2-entry skid buffer, so upstream never depends combinationally on downstream ready. Stall and flush come from the shared per-stage control vectors, selected by STAGE_IDX. Saturating bubble and stall counters support performance analysis.

## Interface
- DATA_W, 32: payload width in bits.
- STALL_W, 6: width of the stall/flush control vectors.
- STAGE_IDX, 2: bit of stall/flush that controls this stage; must be less than STALL_W.
- NOP_VALUE, 0: DATA_W-bit payload driven on out_data whenever out_valid=0.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  STALL_W  per-stage stall vector; only bit STAGE_IDX is used.
- flush  input  STALL_W  per-stage flush vector; only bit STAGE_IDX is used.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  main entry holds a valid payload.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main-entry payload, or NOP_VALUE when invalid.
- bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0.
- stall_cnt  output  CNT_W  saturating count of cycles with stall[STAGE_IDX]=1.

## Operation
- Storage: main entry (main_v, main_d) drives the outputs. Skid entry (skid_v, skid_d) is internal.
- Occupancy states: EMPTY (main_v=0), ONE (main_v=1, skid_v=0), FULL (both valid). The state main_v=0 with skid_v=1 is illegal and never reached.
- in_ready = !skid_v, held in a flop. It must not depend combinationally on out_ready, stall or flush.
- in_fire = in_valid & in_ready & !stall[IDX] & !flush[IDX].
- out_fire = main_v & out_ready & !stall[IDX] & !flush[IDX].
- Transitions:
  - EMPTY: in_fire loads main from in_data and goes to ONE.
  - ONE: in_fire & out_fire loads main from in_data and stays in ONE. in_fire alone loads skid from in_data and goes to FULL. out_fire alone goes to EMPTY.
  - FULL: out_fire moves skid to main and goes to ONE. Otherwise the state holds.
- Stall (stall[IDX]=1, flush[IDX]=0): all state frozen, no fires on either side. Outputs hold. Downstream must not treat out_ready&out_valid as a transfer during stall; out_valid stays asserted.
- Flush (flush[IDX]=1): both entries are invalidated and both data registers are set to NOP_VALUE, regardless of stall, in_valid or out_ready. The in_data offered that cycle is dropped. in_ready becomes 1 next cycle.
- Priority order: reset, then flush, then stall, then handshake.
- out_data equals main_d when main_v=1, otherwise NOP_VALUE. main_d is reloaded with NOP_VALUE on every transition into EMPTY.
- Counters:
  - bubble_cnt increments on each clock edge where main_v=0 before the edge.
  - stall_cnt increments on each clock edge where stall[IDX]=1.
  - Both saturate at all-ones and are not cleared by flush.

## Timing
- Reset (rst=0, asynchronous): main_v=0, skid_v=0, in_ready=1, out_valid=0, out_data=NOP_VALUE, bubble_cnt=0, stall_cnt=0. Deassertion is taken synchronously; the first fire is possible on the first rising edge with rst=1.
- Reset asserted mid-transfer discards both entries immediately, without waiting for a clock.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one payload per cycle while out_ready=1 and no stall.
- When out_ready drops, at most one further payload is absorbed into skid, then in_ready falls at the next edge.
- Order preserved: skid always drains to main before any newer payload.
- Stall held for K cycles delays all traffic by exactly K cycles and adds K to stall_cnt.

## Test plan
- Reset, then stream in_data=0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_data=0x11,0x22,0x33 on consecutive cycles, one cycle after each is accepted; in_ready stays 1; bubble_cnt=1.
- With main holding 0xA0, drop out_ready for 3 cycles while in_valid=1 offers 0xA1,0xA2 -> 0xA1 is captured into skid and in_ready falls; after out_ready rises, out_data=0xA0,0xA1,0xA2 in order with no loss or duplication.
- Assert stall[2] for 4 cycles with FULL occupancy and out_ready=1 -> out_data is frozen, there are no transfers, stall_cnt=4, then normal drain resumes.
- Assert flush[2] with FULL occupancy, with stall[2]=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1; the offered payload never appears.
- Pull rst low asynchronously between edges while in FULL -> outputs take their reset values immediately; after release, 0x5A is accepted and appears after one cycle.
- Run with CNT_W=4 and the stage idle for 20 cycles -> bubble_cnt saturates at 0xF and does not wrap.
